// File: rtl/mux_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mux_ctrl_pkg
//   Shared definitions for the pin-mux controller: command opcodes, the NAK
//   response byte, the control FSM state encoding and a byte-count helper.
// ---------------------------------------------------------------------------
package mux_ctrl_pkg;

   localparam logic [7:0] OP_RD_EN  = 8'h01;
   localparam logic [7:0] OP_RD_MAP = 8'h02;
   localparam logic [7:0] OP_WR_EN  = 8'h03;
   localparam logic [7:0] OP_WR_MAP = 8'h04;
   localparam logic [7:0] OP_RD_IN  = 8'h05;
   localparam logic [7:0] NAK_BYTE  = 8'hEE;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WR_EN  = 2'd1,
      ST_WR_MAP = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   // Number of bytes needed to carry a value of the given bit width.
   function automatic int bytes_for(input int bits);
      return (bits + 7) / 8;
   endfunction

endpackage

// File: rtl/mux_ctrl_resp.sv
// ---------------------------------------------------------------------------
// mux_ctrl_resp
//   Response buffer and byte sequencer. A load captures up to BUF_BYTES bytes
//   plus a length; bytes are then presented least-significant first on a
//   valid/ready handshake.
//
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data/load_len (one-cycle strobe)
//   load_data  : response payload, byte 0 = bits [7:0]
//   load_len   : number of bytes to send (>= 1)
//   tx_ready   : sink accepts tx_data this cycle
//   tx_valid   : a response byte is presented
//   tx_data    : current response byte (0 when idle)
//   done       : last byte accepted this cycle
// ---------------------------------------------------------------------------
module mux_ctrl_resp #(
   parameter int BUF_BYTES = 4,
   parameter int LEN_W     = $clog2(BUF_BYTES + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [BUF_BYTES*8-1:0] load_data,
   input  logic [LEN_W-1:0]       load_len,
   input  logic                   tx_ready,
   output logic                   tx_valid,
   output logic [7:0]             tx_data,
   output logic                   done
);

   logic [BUF_BYTES*8-1:0] buf_q;
   logic [LEN_W-1:0]       left_q;
   logic                   accept;

   assign accept  = tx_valid & tx_ready;
   assign done    = accept & (left_q == LEN_W'(1));
   // The buffer shifts down as bytes leave, so the current byte is always at
   // the bottom and zeros fill in behind it.
   assign tx_data = buf_q[7:0];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q    <= '0;
         left_q   <= '0;
         tx_valid <= 1'b0;
      end else if (load) begin
         buf_q    <= load_data;
         left_q   <= load_len;
         tx_valid <= (load_len != '0);
      end else if (accept) begin
         if (left_q == LEN_W'(1)) begin
            buf_q    <= '0;
            left_q   <= '0;
            tx_valid <= 1'b0;
         end else begin
            buf_q  <= buf_q >> 8;
            left_q <= left_q - LEN_W'(1);
         end
      end
   end

endmodule

// File: rtl/mux_ctrl.sv
// ---------------------------------------------------------------------------
// mux_ctrl
//   Byte-command controller for a pin multiplexer. Commands arrive as bytes on
//   rx_*; write commands fill a shadow register and commit it atomically to
//   enabled_out/selectors once the frame is complete; every command produces
//   a response on tx_*. Protocol errors pulse err_pulse and answer NAK.
//
//   clk, rst    : clock, synchronous active-high reset
//   rx_valid    : rx_data holds a received byte (one-cycle strobe)
//   rx_data     : received byte
//   tx_valid    : response byte available
//   tx_data     : response byte
//   tx_ready    : transmitter accepts tx_data this cycle
//   in_pins     : pin levels returned by the read-inputs command
//   selectors   : per-output input select, output k at [k*SW +: SW]
//   enabled_out : per-output enable mask
//   err_pulse   : one-cycle pulse per protocol error
// ---------------------------------------------------------------------------
module mux_ctrl
   import mux_ctrl_pkg::*;
#(
   parameter int OUTPUT_COUNT   = 16,
   parameter int INPUT_COUNT    = 4,
   parameter int TIMEOUT_CYCLES = 65535,
   localparam int SW            = $clog2(INPUT_COUNT),
   localparam int SEL_W         = SW * OUTPUT_COUNT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_data,
   output logic                    tx_valid,
   output logic [7:0]              tx_data,
   input  logic                    tx_ready,
   input  logic [INPUT_COUNT-1:0]  in_pins,
   output logic [SEL_W-1:0]        selectors,
   output logic [OUTPUT_COUNT-1:0] enabled_out,
   output logic                    err_pulse
);

   localparam int EN_BYTES  = bytes_for(OUTPUT_COUNT);
   localparam int MAP_BYTES = bytes_for(SEL_W);
   localparam int IN_BYTES  = bytes_for(INPUT_COUNT);
   localparam int BUF_BYTES = (EN_BYTES > MAP_BYTES)
                              ? ((EN_BYTES > IN_BYTES) ? EN_BYTES : IN_BYTES)
                              : ((MAP_BYTES > IN_BYTES) ? MAP_BYTES : IN_BYTES);
   localparam int BUF_W     = BUF_BYTES * 8;
   localparam int CNT_W     = $clog2(BUF_BYTES + 1);
   localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       byte_cnt_q;
   logic [TO_W-1:0]        idle_cnt_q;
   logic [EN_BYTES*8-1:0]  en_shadow_q, en_merged;
   logic [MAP_BYTES*8-1:0] map_shadow_q, map_merged;

   logic                   resp_load;
   logic [BUF_W-1:0]       resp_data;
   logic [CNT_W-1:0]       resp_len;
   logic                   resp_done;
   logic                   err_d;
   logic                   commit_en, commit_map;
   logic                   frame_active;

   // A write frame stays open only while the FSM remains in its write state;
   // any exit (commit, timeout) discards the partial shadow and counters.
   assign frame_active = ((state_q == ST_WR_EN) || (state_q == ST_WR_MAP))
                         && (state_d == state_q);

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case leaves a value held and infers a latch.
   always_comb begin
      state_d    = state_q;
      resp_load  = 1'b0;
      resp_data  = '0;
      resp_len   = '0;
      err_d      = 1'b0;
      commit_en  = 1'b0;
      commit_map = 1'b0;

      // Shadow with the incoming byte merged at byte_cnt; this is also the
      // value committed when the frame's final byte arrives.
      en_merged  = en_shadow_q;
      map_merged = map_shadow_q;
      for (int b = 0; b < EN_BYTES; b++)
         if (byte_cnt_q == CNT_W'(b)) en_merged[b*8 +: 8] = rx_data;
      for (int b = 0; b < MAP_BYTES; b++)
         if (byte_cnt_q == CNT_W'(b)) map_merged[b*8 +: 8] = rx_data;

      case (state_q)
         ST_IDLE: begin
            if (rx_valid) begin
               case (rx_data)
                  OP_WR_EN:  state_d = ST_WR_EN;
                  OP_WR_MAP: state_d = ST_WR_MAP;
                  OP_RD_EN: begin
                     state_d   = ST_RESP;
                     resp_load = 1'b1;
                     resp_data = BUF_W'(enabled_out);
                     resp_len  = CNT_W'(EN_BYTES);
                  end
                  OP_RD_MAP: begin
                     state_d   = ST_RESP;
                     resp_load = 1'b1;
                     resp_data = BUF_W'(selectors);
                     resp_len  = CNT_W'(MAP_BYTES);
                  end
                  OP_RD_IN: begin
                     state_d   = ST_RESP;
                     resp_load = 1'b1;
                     resp_data = BUF_W'(in_pins);
                     resp_len  = CNT_W'(IN_BYTES);
                  end
                  default: begin
                     state_d   = ST_RESP;
                     resp_load = 1'b1;
                     resp_data = BUF_W'(NAK_BYTE);
                     resp_len  = CNT_W'(1);
                     err_d     = 1'b1;
                  end
               endcase
            end
         end

         ST_WR_EN, ST_WR_MAP: begin
            if (rx_valid) begin
               if (state_q == ST_WR_EN && byte_cnt_q == CNT_W'(EN_BYTES - 1)) begin
                  state_d   = ST_RESP;
                  commit_en = 1'b1;
                  resp_load = 1'b1;
                  resp_data = BUF_W'(en_merged[OUTPUT_COUNT-1:0]);
                  resp_len  = CNT_W'(EN_BYTES);
               end else if (state_q == ST_WR_MAP &&
                            byte_cnt_q == CNT_W'(MAP_BYTES - 1)) begin
                  state_d    = ST_RESP;
                  commit_map = 1'b1;
                  resp_load  = 1'b1;
                  resp_data  = BUF_W'(map_merged[SEL_W-1:0]);
                  resp_len   = CNT_W'(MAP_BYTES);
               end
            end else if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
               // This idle cycle is the TIMEOUT_CYCLES-th in a row.
               state_d   = ST_RESP;
               resp_load = 1'b1;
               resp_data = BUF_W'(NAK_BYTE);
               resp_len  = CNT_W'(1);
               err_d     = 1'b1;
            end
         end

         ST_RESP: begin
            if (rx_valid) err_d = 1'b1;
            if (resp_done) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_q   <= '0;
         idle_cnt_q   <= '0;
         en_shadow_q  <= '0;
         map_shadow_q <= '0;
         enabled_out  <= '0;
         selectors    <= '0;
         err_pulse    <= 1'b0;
      end else begin
         err_pulse <= err_d;
         if (commit_en)  enabled_out <= en_merged[OUTPUT_COUNT-1:0];
         if (commit_map) selectors   <= map_merged[SEL_W-1:0];

         if (frame_active) begin
            if (rx_valid) begin
               byte_cnt_q <= byte_cnt_q + CNT_W'(1);
               idle_cnt_q <= '0;
               if (state_q == ST_WR_EN) en_shadow_q  <= en_merged;
               else                     map_shadow_q <= map_merged;
            end else begin
               idle_cnt_q <= idle_cnt_q + TO_W'(1);
            end
         end else begin
            byte_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            en_shadow_q  <= '0;
            map_shadow_q <= '0;
         end
      end
   end

   mux_ctrl_resp #(
      .BUF_BYTES (BUF_BYTES),
      .LEN_W     (CNT_W)
   ) u_resp (
      .clk       (clk),
      .rst       (rst),
      .load      (resp_load),
      .load_data (resp_data),
      .load_len  (resp_len),
      .tx_ready  (tx_ready),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .done      (resp_done)
   );

endmodule

// File: tb/tb_mux_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux_ctrl
//   Self-checking bench for mux_ctrl: directed command scenarios followed by
//   randomized command traffic, compared against a byte-level command model.
// ---------------------------------------------------------------------------
module tb_mux_ctrl;

   localparam int OC        = 16;
   localparam int IC        = 4;
   localparam int TO        = 40;
   localparam int SW        = $clog2(IC);
   localparam int SEL_W     = SW * OC;
   localparam int EN_BYTES  = (OC + 7) / 8;
   localparam int MAP_BYTES = (SEL_W + 7) / 8;
   localparam int IN_BYTES  = (IC + 7) / 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             rx_valid;
   logic [7:0]       rx_data;
   logic             tx_valid;
   logic [7:0]       tx_data;
   logic             tx_ready;
   logic [IC-1:0]    in_pins;
   logic [SEL_W-1:0] selectors;
   logic [OC-1:0]    enabled_out;
   logic             err_pulse;

   mux_ctrl #(
      .OUTPUT_COUNT   (OC),
      .INPUT_COUNT    (IC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .in_pins     (in_pins),
      .selectors   (selectors),
      .enabled_out (enabled_out),
      .err_pulse   (err_pulse)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int err_seen    = 0;

   // Reference state: the committed values the outputs should show.
   logic [63:0] m_en;
   logic [63:0] m_map;

   logic [7:0] payload[$];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];

   always @(posedge clk) begin
      if (!rst && err_pulse === 1'b1) err_seen++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mask_bits(input int n);
      return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   // Append the n low bytes of v, least significant first.
   task automatic push_value(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(8'((v >> (8 * i)) & 64'hFF));
   endtask

   // Accept n response bytes, optionally stalling tx_ready low first.
   task automatic collect(input int n, input int stall);
      got_q.delete();
      for (int i = 0; i < n; i++) begin
         int w = 0;
         logic [7:0] held;
         while (tx_valid !== 1'b1 && w < 100) begin
            tick();
            w++;
         end
         check("tx_valid_wait", 64'(tx_valid), 64'd1);
         held = tx_data;
         for (int s = 0; s < stall; s++) begin
            tick();
            check("tx_data_stable", 64'(tx_data), 64'(held));
            check("tx_valid_stall", 64'(tx_valid), 64'd1);
         end
         got_q.push_back(tx_data);
         tx_ready = 1'b1;
         tick();
         tx_ready = 1'b0;
      end
      check("tx_valid_drop", 64'(tx_valid), 64'd0);
   endtask

   task automatic compare_resp(input string tag);
      check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_byte"}, 64'(got_q[i]), 64'(exp_q[i]));
   endtask

   // One complete command: opcode plus the global payload, then the response.
   task automatic do_cmd(input logic [7:0] op, input int stall);
      int          err0 = err_seen;
      int          exp_err = 0;
      logic [63:0] v;
      logic [IC-1:0] pins_at_op;
      exp_q.delete();
      pins_at_op = in_pins;
      send_byte(op);
      in_pins = IC'($urandom);
      foreach (payload[i]) begin
         check("mid_frame_en",  64'(enabled_out), m_en);
         check("mid_frame_map", 64'(selectors),   m_map);
         send_byte(payload[i]);
      end
      case (op)
         8'h01: push_value(m_en, EN_BYTES);
         8'h02: push_value(m_map, MAP_BYTES);
         8'h05: push_value(64'(pins_at_op), IN_BYTES);
         8'h03, 8'h04: begin
            v = '0;
            foreach (payload[i]) v |= 64'(payload[i]) << (8 * i);
            if (op == 8'h03) begin
               m_en = v & mask_bits(OC);
               push_value(m_en, EN_BYTES);
            end else begin
               m_map = v & mask_bits(SEL_W);
               push_value(m_map, MAP_BYTES);
            end
         end
         default: begin
            exp_q.push_back(8'hEE);
            exp_err = 1;
         end
      endcase
      collect(exp_q.size(), stall);
      compare_resp("resp");
      check("err_count", 64'(err_seen - err0), 64'(exp_err));
      check("enabled_out", 64'(enabled_out), m_en);
      check("selectors",   64'(selectors),   m_map);
   endtask

   initial begin
      int err0;
      int w;
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b0;
      in_pins  = '0;
      m_en     = '0;
      m_map    = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state.
      check("rst_enabled_out", 64'(enabled_out), 64'd0);
      check("rst_selectors",   64'(selectors),   64'd0);
      check("rst_tx_valid",    64'(tx_valid),    64'd0);
      check("rst_tx_data",     64'(tx_data),     64'd0);
      check("rst_err_pulse",   64'(err_pulse),   64'd0);

      // Write enable mask, little-endian.
      payload = '{8'h34, 8'h12};
      do_cmd(8'h03, 0);
      check("wr_en_value", 64'(enabled_out), 64'h1234);

      // Write selector map with a long tx_ready stall.
      payload = '{8'hE4, 8'hE4, 8'hE4, 8'hE4};
      do_cmd(8'h04, 10);
      check("wr_map_value", 64'(selectors), 64'hE4E4E4E4);

      // Unknown opcode.
      payload.delete();
      do_cmd(8'h07, 0);

      // Frame timeout after a partial write.
      err0 = err_seen;
      send_byte(8'h03);
      send_byte(8'hFF);
      w = 0;
      while (tx_valid !== 1'b1 && w < 3 * TO) begin
         check("timeout_hold_en", 64'(enabled_out), m_en);
         tick();
         w++;
      end
      check("timeout_latency_ok", 64'((w >= TO - 2) && (w <= TO + 2)), 64'd1);
      exp_q = '{8'hEE};
      collect(1, 0);
      compare_resp("timeout_resp");
      check("timeout_err", 64'(err_seen - err0), 64'd1);
      check("timeout_en", 64'(enabled_out), m_en);

      // Byte arriving during a response is dropped with an error.
      err0 = err_seen;
      send_byte(8'h01);
      send_byte(8'h02);
      exp_q.delete();
      push_value(m_en, EN_BYTES);
      collect(EN_BYTES, 0);
      compare_resp("resp_drop");
      repeat (3) begin
         tick();
         check("resp_drop_idle", 64'(tx_valid), 64'd0);
      end
      check("resp_drop_err", 64'(err_seen - err0), 64'd1);

      // Reset in the middle of a map frame abandons it.
      send_byte(8'h04);
      send_byte(8'h11);
      send_byte(8'h22);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_en  = '0;
      m_map = '0;
      check("midrst_enabled_out", 64'(enabled_out), 64'd0);
      check("midrst_selectors",   64'(selectors),   64'd0);
      check("midrst_tx_valid",    64'(tx_valid),    64'd0);
      payload.delete();
      do_cmd(8'h02, 0);

      // Randomized command traffic.
      for (int t = 0; t < 60; t++) begin
         logic [7:0] op;
         int         kind = $urandom_range(0, 5);
         int         n;
         payload.delete();
         in_pins = IC'($urandom);
         case (kind)
            0: op = 8'h01;
            1: op = 8'h02;
            2: op = 8'h03;
            3: op = 8'h04;
            4: op = 8'h05;
            default: begin
               op = 8'($urandom_range(6, 255));
               if ($urandom_range(0, 3) == 0) op = 8'h00;
            end
         endcase
         n = (op == 8'h03) ? EN_BYTES : (op == 8'h04) ? MAP_BYTES : 0;
         for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
         do_cmd(op, $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
